// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial shifter with a one-word hold buffer so consecutive
// frames leave dout_valid high with no idle cycle between them.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             ser_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_reg;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             hold_full;
    logic [CW-1:0]    bit_cnt;
    logic             accept;
    logic             last_edge;
    logic             load;

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign in_ready  = !hold_full && !rst;
    assign accept    = in_valid && in_ready;
    assign sreg_next = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign last_edge = (state == SHIFT) && ser_en && (bit_cnt == LAST);
    // A held word starts immediately from IDLE, or replaces the finishing frame on its last edge.
    assign load      = hold_full && ((state == IDLE) || last_edge);
    assign busy      = (state == SHIFT) || hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hold_reg   <= '0;
            hold_full  <= 1'b0;
            sreg       <= '0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
        end else begin
            frame_done <= last_edge;
            if (accept) begin
                hold_reg  <= in_data;
                hold_full <= 1'b1;
            end
            if (load) begin
                sreg       <= hold_reg;
                hold_full  <= 1'b0;
                bit_cnt    <= '0;
                state      <= SHIFT;
                dout       <= head(hold_reg);
                dout_valid <= 1'b1;
            end else if (last_edge) begin
                state      <= IDLE;
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
            end else if (state == SHIFT && ser_en) begin
                sreg    <= sreg_next;
                bit_cnt <= bit_cnt + CW'(1);
                dout    <= head(sreg_next);
            end
        end
    end
endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8: bits per parallel word; legal range WIDTH >= 2.
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = transmit bit WIDTH-1 first, 0 = transmit bit 0 first.
REQ-003 SHALL provide parameter IDLE_BIT, default 0: dout level while no frame is active.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  WIDTH  parallel word to serialize.
REQ-007 in_valid  input  1  in_data is valid.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 ser_en  input  1  bit-advance tick (baud enable); may be held high permanently.
REQ-010 dout  output  1  serial bit stream; feeds the serial din input of the downstream detector FSM.
REQ-011 dout_valid  output  1  dout carries a frame bit.
REQ-012 frame_done  output  1  one-cycle pulse after the last bit of a frame is consumed.
REQ-013 busy  output  1  a frame is in flight or a word is buffered.

Function
REQ-014 SHALL contain a one-word hold register (flag hold_full), a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and a two-state FSM: IDLE, SHIFT.
REQ-015 in_ready SHALL equal !hold_full && !rst, with no combinational path from in_valid.
REQ-016 A transfer SHALL occur on a rising edge where in_valid && in_ready; in_data is captured into the hold register and hold_full is set.
REQ-017 IDLE with hold_full: the next edge loads the shift register from hold, clears hold_full, zeroes bit_cnt, and enters SHIFT; ser_en is not required.
REQ-018 Latency: a word accepted at edge N while IDLE SHALL present its first bit on dout after edge N+1.
REQ-019 In IDLE: dout = IDLE_BIT, dout_valid = 0; ser_en is ignored.
REQ-020 In SHIFT: dout_valid = 1; dout = the current bit per MSB_FIRST; dout SHALL be derived from registers only (glitch-free).
REQ-021 In SHIFT, an edge with ser_en = 0 SHALL hold dout, the shift register and bit_cnt unchanged.
REQ-022 In SHIFT, an edge with ser_en = 1 and bit_cnt < WIDTH-1 SHALL shift to the next bit and increment bit_cnt.
REQ-023 In SHIFT, an edge with ser_en = 1 and bit_cnt = WIDTH-1 (last bit) SHALL set frame_done high for exactly the following cycle.
REQ-024 At the last-bit edge with hold_full = 1: reload from hold, clear hold_full, bit_cnt = 0, stay in SHIFT, giving back-to-back frames with zero idle cycles.
REQ-025 At the last-bit edge with hold_full = 0: go to IDLE; a word accepted on that same edge enters hold and loads on the next edge (one idle cycle).
REQ-026 An accept and a reload on the same edge cannot coincide, since in_ready = 0 whenever hold_full = 1.
REQ-027 busy SHALL equal (state == SHIFT) || hold_full.

Reset
REQ-028 While rst = 1 at an edge: state = IDLE, hold_full = 0, shift register = 0, bit_cnt = 0, frame_done = 0, dout = IDLE_BIT, dout_valid = 0, busy = 0.
REQ-029 in_ready SHALL be 0 while rst is asserted and 1 in the first cycle after rst deasserts.
REQ-030 A reset during SHIFT SHALL discard the current frame and the held word, with no frame_done pulse.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1, ser_en=1, send 0xA5 -> dout 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after edge N+1; dout_valid high for exactly those 8 cycles; frame_done high one cycle after the 8th bit.
REQ-032 Send 0xFF then 0x00 with in_valid held high -> 16 contiguous dout_valid cycles (8 ones, 8 zeros); no gap; two frame_done pulses 8 cycles apart.
REQ-033 ser_en pulsed every 3rd cycle, send 0x3C -> each bit held exactly 3 cycles; total frame length 24 cycles.
REQ-034 Reset asserted after 3 bits of 0xF0 -> next cycle dout = IDLE_BIT, dout_valid = 0, busy = 0, no frame_done; in_ready = 1 the cycle after rst deasserts.
REQ-035 MSB_FIRST=0, send 0x01 -> first dout bit = 1, remaining 7 bits = 0.
REQ-036 Three words offered continuously -> third word sees in_ready = 0 until the first frame completes, then is accepted with no data loss and in order.
